// File: rtl/sgm_math_pkg.sv
// Shared integer-math helpers for the SGM datapath.
// clog2 maps 0 and 1 to 0 and is usable in constant expressions.
package sgm_math_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  localparam int WIDTH = 9;
  localparam int SW    = clog2(WIDTH);
  localparam int P     = 1 << SW;
  localparam int LW    = clog2(WIDTH + 1);

endpackage

// File: rtl/log2_search_stage.sv
// One binary-search step of log2_pipe: tests the upper half of the window,
// records one floor bit and forwards the selected half.
module log2_search_stage #(
  parameter int  STAGE = 1,
  parameter int  SW    = 4,
  parameter int  P     = 16,
  parameter int  LW    = 4,
  parameter int  TAG_W = 4,
  localparam int WI    = P >> (STAGE - 1),
  localparam int WO    = WI / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WI-1:0]    win_i,
  input  logic [LW-1:0]    floor_i,
  input  logic             zero_i,
  input  logic             pow2_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic [WO-1:0]    win_o,
  output logic [LW-1:0]    floor_o,
  output logic             zero_o,
  output logic             pow2_o,
  output logic [TAG_W-1:0] tag_o
);

  logic             upper_nz_s;
  logic [WO-1:0]    win_d;
  logic [LW-1:0]    floor_d;

  logic             valid_q;
  logic [WO-1:0]    win_q;
  logic [LW-1:0]    floor_q;
  logic             zero_q;
  logic             pow2_q;
  logic [TAG_W-1:0] tag_q;

  // Select the half that holds the most significant set bit.
  always_comb begin
    upper_nz_s        = |win_i[WI-1:WO];
    floor_d           = floor_i;
    floor_d[SW-STAGE] = upper_nz_s;
    if (upper_nz_s) begin
      win_d = win_i[WI-1:WO];
    end else begin
      win_d = win_i[WO-1:0];
    end
  end

  // Stage register; holds while the pipeline is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      win_q   <= {WO{1'b0}};
      floor_q <= {LW{1'b0}};
      zero_q  <= 1'b0;
      pow2_q  <= 1'b0;
      tag_q   <= {TAG_W{1'b0}};
    end else if (en_i) begin
      valid_q <= valid_i;
      win_q   <= win_d;
      floor_q <= floor_d;
      zero_q  <= zero_i;
      pow2_q  <= pow2_i;
      tag_q   <= tag_i;
    end
  end

  assign valid_o = valid_q;
  assign win_o   = win_q;
  assign floor_o = floor_q;
  assign zero_o  = zero_q;
  assign pow2_o  = pow2_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/log2_pipe.sv
// Pipelined floor/ceil log2 with zero and power-of-two flags and a tag sideband.
// Input register, SW binary-search stages, registered result stage; one global stall enable.
module log2_pipe
  import sgm_math_pkg::clog2;
#(
  parameter int  WIDTH = sgm_math_pkg::WIDTH,
  parameter int  TAG_W = 4,
  localparam int SW    = clog2(WIDTH),
  localparam int P     = 1 << SW,
  localparam int LW    = clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    out_floor,
  output logic [LW-1:0]    out_ceil,
  output logic             out_zero,
  output logic             out_pow2,
  output logic [TAG_W-1:0] out_tag
);

  logic             en_s;

  logic             s0_zero_d;
  logic             s0_pow2_d;
  logic             s0_valid_q;
  logic [P-1:0]     s0_data_q;
  logic             s0_zero_q;
  logic             s0_pow2_q;
  logic [TAG_W-1:0] s0_tag_q;

  logic             valid_a [0:SW];
  logic [P-1:0]     win_a   [0:SW];
  logic [LW-1:0]    floor_a [0:SW];
  logic             zero_a  [0:SW];
  logic             pow2_a  [0:SW];
  logic [TAG_W-1:0] tag_a   [0:SW];

  logic             inc_s;
  logic [LW-1:0]    ceil_d;

  logic             out_valid_q;
  logic [LW-1:0]    out_floor_q;
  logic [LW-1:0]    out_ceil_q;
  logic             out_zero_q;
  logic             out_pow2_q;
  logic [TAG_W-1:0] out_tag_q;

  assign en_s     = !out_valid_q || out_ready;
  assign in_ready = en_s;

  // Operand flags computed at full input width before zero extension.
  always_comb begin
    s0_zero_d = (in_data == {WIDTH{1'b0}});
    s0_pow2_d = !s0_zero_d &&
                ((in_data & (in_data - {{(WIDTH-1){1'b0}}, 1'b1})) == {WIDTH{1'b0}});
  end

  // Input register; an unaccepted cycle enters the pipe as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_data_q  <= {P{1'b0}};
      s0_zero_q  <= 1'b0;
      s0_pow2_q  <= 1'b0;
      s0_tag_q   <= {TAG_W{1'b0}};
    end else if (en_s) begin
      s0_valid_q <= in_valid;
      s0_data_q  <= P'(in_data);
      s0_zero_q  <= s0_zero_d;
      s0_pow2_q  <= s0_pow2_d;
      s0_tag_q   <= in_tag;
    end
  end

  assign valid_a[0] = s0_valid_q;
  assign win_a[0]   = s0_data_q;
  assign floor_a[0] = {LW{1'b0}};
  assign zero_a[0]  = s0_zero_q;
  assign pow2_a[0]  = s0_pow2_q;
  assign tag_a[0]   = s0_tag_q;

  for (genvar k = 1; k <= SW; k++) begin : g_stage
    localparam int WI = P >> (k - 1);
    localparam int WO = WI / 2;
    logic [WO-1:0] win_s;

    log2_search_stage #(
      .STAGE (k),
      .SW    (SW),
      .P     (P),
      .LW    (LW),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en_s),
      .valid_i (valid_a[k-1]),
      .win_i   (win_a[k-1][WI-1:0]),
      .floor_i (floor_a[k-1]),
      .zero_i  (zero_a[k-1]),
      .pow2_i  (pow2_a[k-1]),
      .tag_i   (tag_a[k-1]),
      .valid_o (valid_a[k]),
      .win_o   (win_s),
      .floor_o (floor_a[k]),
      .zero_o  (zero_a[k]),
      .pow2_o  (pow2_a[k]),
      .tag_o   (tag_a[k])
    );

    assign win_a[k] = P'(win_s);
  end

  // The surviving window bit is set exactly when the operand was nonzero.
  always_comb begin
    inc_s  = win_a[SW][0] && !pow2_a[SW];
    ceil_d = floor_a[SW] + {{(LW-1){1'b0}}, inc_s};
  end

  // Result register; outputs stay frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_floor_q <= {LW{1'b0}};
      out_ceil_q  <= {LW{1'b0}};
      out_zero_q  <= 1'b0;
      out_pow2_q  <= 1'b0;
      out_tag_q   <= {TAG_W{1'b0}};
    end else if (en_s) begin
      out_valid_q <= valid_a[SW];
      out_floor_q <= floor_a[SW];
      out_ceil_q  <= ceil_d;
      out_zero_q  <= zero_a[SW];
      out_pow2_q  <= pow2_a[SW];
      out_tag_q   <= tag_a[SW];
    end
  end

  assign out_valid = out_valid_q;
  assign out_floor = out_floor_q;
  assign out_ceil  = out_ceil_q;
  assign out_zero  = out_zero_q;
  assign out_pow2  = out_pow2_q;
  assign out_tag   = out_tag_q;

endmodule
